// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_pkg
// Description : Shared SISC datapath widths and drain-FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_pkg;

    localparam int c_AW = 16;
    localparam int c_DW = 32;

    typedef logic [1:0] drain_state_t;

    localparam drain_state_t c_ST_IDLE   = 2'd0;
    localparam drain_state_t c_ST_SETUP  = 2'd1;
    localparam drain_state_t c_ST_STROBE = 2'd2;
    localparam drain_state_t c_ST_HOLD   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_match
// Description : DEPTH-way load/store address compare, youngest valid hit wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_match
    import sisc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = c_AW
) (
    input  logic [AW-1:0]               i_ld_addr,
    input  logic [DEPTH-1:0][AW-1:0]    i_entry_addr,
    input  logic [$clog2(DEPTH)-1:0]    i_head,
    input  logic [$clog2(DEPTH):0]      i_count,
    output logic                        o_hit,
    output logic [$clog2(DEPTH)-1:0]    o_hit_idx
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_PTR_W-1:0] w_idx;

    // Walk oldest to youngest from head so a later (younger) hit overrides.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < i_count) && (i_entry_addr[w_idx] == i_ld_addr)) begin
                o_hit     = 1'b1;
                o_hit_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dm_store_buffer
// Description : In-order store queue draining to dm via SETUP/STROBE/HOLD,
//               with youngest-match load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_store_buffer
    import sisc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = c_AW,
    parameter int DW    = c_DW
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_fwd,
    output logic          buf_empty,
    output logic [AW-1:0] dm_read_addr,
    input  logic [DW-1:0] dm_read_data,
    output logic [AW-1:0] dm_write_addr,
    output logic [DW-1:0] dm_write_data,
    output logic          dm_we
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] r_addr_q;
    logic [DW-1:0]            r_data_q [DEPTH];
    logic [c_PTR_W-1:0]       r_head;
    logic [c_PTR_W-1:0]       r_tail;
    logic [c_CNT_W-1:0]       r_count;
    drain_state_t             r_state;
    logic [AW-1:0]            r_wr_addr;
    logic [DW-1:0]            r_wr_data;
    logic                     r_we;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_hit;
    logic [c_PTR_W-1:0]       w_hit_idx;
    logic [c_PTR_W-1:0]       w_head_nxt;

    assign st_ready      = (r_count < c_DEPTH);
    assign w_push        = st_valid & st_ready;
    assign w_pop         = (r_state == c_ST_HOLD);
    assign w_head_nxt    = r_head + c_PTR_W'(1);
    assign buf_empty     = (r_count == '0) && (r_state == c_ST_IDLE);
    assign dm_read_addr  = ld_addr;
    assign dm_write_addr = r_wr_addr;
    assign dm_write_data = r_wr_data;
    assign dm_we         = r_we;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_tail] <= st_addr;
            r_data_q[r_tail] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_state   <= c_ST_IDLE;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_we      <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end

            // Write address/data only move on entry to SETUP, so dm sees them stable.
            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state   <= c_ST_SETUP;
                        r_wr_addr <= r_addr_q[r_head];
                        r_wr_data <= r_data_q[r_head];
                    end
                end
                c_ST_SETUP: begin
                    r_state <= c_ST_STROBE;
                    r_we    <= 1'b1;
                end
                c_ST_STROBE: begin
                    r_state <= c_ST_HOLD;
                    r_we    <= 1'b0;
                end
                c_ST_HOLD: begin
                    if (r_count > c_CNT_W'(1)) begin
                        r_state   <= c_ST_SETUP;
                        r_wr_addr <= r_addr_q[w_head_nxt];
                        r_wr_data <= r_data_q[w_head_nxt];
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fwd_match (
        .i_ld_addr    (ld_addr),
        .i_entry_addr (r_addr_q),
        .i_head       (r_head),
        .i_count      (r_count),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx)
    );

    assign ld_fwd  = w_hit;
    assign ld_data = w_hit ? r_data_q[w_hit_idx] : dm_read_data;

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_store_buffer
// Description : Directed bench for dm_store_buffer with a negedge dm model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_f;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic          buf_empty;
    logic [AW-1:0] dm_read_addr;
    logic [DW-1:0] dm_read_data;
    logic [AW-1:0] dm_write_addr;
    logic [DW-1:0] dm_write_data;
    logic          dm_we;

    always #5 clk = ~clk;

    dm_store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_ready      (st_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_fwd        (ld_fwd),
        .buf_empty     (buf_empty),
        .dm_read_addr  (dm_read_addr),
        .dm_read_data  (dm_read_data),
        .dm_write_addr (dm_write_addr),
        .dm_write_data (dm_write_data),
        .dm_we         (dm_we)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           expq[$];
    logic [DW-1:0] mem [256];
    logic          mem_init = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_we = 0;
    int            last_we_cyc = -1;
    bit            spacing_on = 1'b0;
    int            base;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    assign dm_read_data = mem[dm_read_addr[7:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // dm model: commits on the clock falling edge while dm_we is high.
    always @(negedge clk) begin
        wr_t e;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(AW'(i));
            mem_init <= 1'b1;
        end
        if (dm_we === 1'b1) begin
            mem[dm_write_addr[7:0]] <= dm_write_data;
            n_we++;
            if (spacing_on && last_we_cyc >= 0) chk("we_spacing", 64'(cyc - last_we_cyc), 64'd3);
            last_we_cyc = cyc;
            if (expq.size() == 0) begin
                chk("unexpected_write", 64'(expq.size()), 64'd1);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", 64'(dm_write_addr), 64'(e.a));
                chk("wr_data", 64'(dm_write_data), 64'(e.d));
            end
        end
    end

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        k        = 0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        while (!st_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("st_ready_wait", 64'(st_ready), 64'd1);
        expq.push_back({a, d});
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int k;
        k = 0;
        while (!buf_empty && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, 64'(buf_empty), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a store request pending
        rst_f    = 1'b0;
        st_valid = 1'b1;
        st_addr  = 16'h0077;
        st_data  = 32'h1111_1111;
        ld_addr  = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_dm_we", 64'(dm_we), 64'd0);
            chk("rst_buf_empty", 64'(buf_empty), 64'd1);
        end
        rst_f    = 1'b1;
        st_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_wr_addr", 64'(dm_write_addr), 64'd0);
        chk("rst_wr_data", 64'(dm_write_data), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_writes", 64'(n_we), 64'd0);
        chk("rst_mem77", 64'(mem[8'h77]), 64'(init_val(16'h0077)));
        chk("rst_empty_idle", 64'(buf_empty), 64'd1);

        // Single store and its SETUP/STROBE/HOLD sequence
        base = n_we;
        store(16'h0005, 32'hDEAD_BEEF);
        chk("t2_accept_we", 64'(dm_we), 64'd0);
        chk("t2_accept_empty", 64'(buf_empty), 64'd0);
        @(posedge clk); #1;
        chk("t2_setup_we", 64'(dm_we), 64'd0);
        chk("t2_setup_addr", 64'(dm_write_addr), 64'h5);
        chk("t2_setup_data", 64'(dm_write_data), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t2_strobe_we", 64'(dm_we), 64'd1);
        chk("t2_strobe_addr", 64'(dm_write_addr), 64'h5);
        chk("t2_strobe_data", 64'(dm_write_data), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t2_hold_we", 64'(dm_we), 64'd0);
        chk("t2_hold_addr", 64'(dm_write_addr), 64'h5);
        chk("t2_hold_data", 64'(dm_write_data), 64'hDEAD_BEEF);
        chk("t2_hold_empty", 64'(buf_empty), 64'd0);
        chk("t2_mem5", 64'(mem[5]), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t2_empty_after4", 64'(buf_empty), 64'd1);
        chk("t2_one_pulse", 64'(n_we - base), 64'd1);

        // Fill past DEPTH; fifth store waits for the first pop
        base        = n_we;
        last_we_cyc = -1;
        spacing_on  = 1'b1;
        for (int i = 0; i < 4; i++) store(16'h0060 + 16'(i), 32'hA000_0000 + 32'(i));
        chk("t3_full_not_ready", 64'(st_ready), 64'd0);
        store(16'h0064, 32'hA000_0004);
        wait_empty("t3_drain_done");
        spacing_on = 1'b0;
        chk("t3_five_pulses", 64'(n_we - base), 64'd5);
        chk("t3_queue_drained", 64'(expq.size()), 64'd0);
        chk("t3_mem64", 64'(mem[8'h64]), 64'hA000_0004);

        // Youngest-match forwarding, then read-through after drain
        store(16'h0010, 32'd1);
        store(16'h0010, 32'd2);
        ld_addr = 16'h0010;
        #1;
        chk("t4_fwd_hit", 64'(ld_fwd), 64'd1);
        chk("t4_fwd_youngest", 64'(ld_data), 64'd2);
        wait_empty("t4_drain_done");
        #1;
        chk("t4_post_fwd", 64'(ld_fwd), 64'd0);
        chk("t4_post_data", 64'(ld_data), 64'd2);

        // Miss with unrelated entries queued; same-cycle store not visible
        store(16'h0021, 32'h2121_2121);
        store(16'h0022, 32'h2222_2222);
        ld_addr = 16'h0020;
        #1;
        chk("t5_miss_fwd", 64'(ld_fwd), 64'd0);
        chk("t5_miss_data", 64'(ld_data), 64'(init_val(16'h0020)));
        ld_addr  = 16'h0040;
        st_valid = 1'b1;
        st_addr  = 16'h0040;
        st_data  = 32'h4444_4444;
        #1;
        chk("t5_same_ready", 64'(st_ready), 64'd1);
        chk("t5_same_cycle_fwd", 64'(ld_fwd), 64'd0);
        expq.push_back({16'h0040, 32'h4444_4444});
        @(posedge clk); #1;
        st_valid = 1'b0;
        chk("t5_next_cycle_fwd", 64'(ld_fwd), 64'd1);
        chk("t5_next_cycle_data", 64'(ld_data), 64'h4444_4444);
        wait_empty("t5_drain_done");

        // Reset while the head entry is in STROBE
        base = n_we;
        store(16'h0050, 32'hB000_0000);
        store(16'h0051, 32'hB000_0001);
        store(16'h0052, 32'hB000_0002);
        chk("t6_in_strobe", 64'(dm_we), 64'd1);
        rst_f = 1'b0;
        @(posedge clk); #1;
        expq.delete();
        chk("t6_rst_we", 64'(dm_we), 64'd0);
        rst_f = 1'b1;
        @(posedge clk); #1;
        chk("t6_empty_after_release", 64'(buf_empty), 64'd1);
        chk("t6_ready_after_release", 64'(st_ready), 64'd1);
        chk("t6_wr_addr_cleared", 64'(dm_write_addr), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_one_pulse", 64'(n_we - base), 64'd1);
        chk("t6_mem50", 64'(mem[8'h50]), 64'hB000_0000);
        chk("t6_mem51_lost", 64'(mem[8'h51]), 64'(init_val(16'h0051)));
        chk("t6_mem52_lost", 64'(mem[8'h52]), 64'(init_val(16'h0052)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
